lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter AW, default 15: word-address width of the data RAM port.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  CPU access request.
REQ-005 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_memop  input  3  memop encoding:
- 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
- Stores use bits [1:0] only: 00 byte, 01 half, 10 word.
REQ-008 req_addr  input  32  byte address; bits [AW+1:0] used.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-012 resp_err  output  1  illegal memop; valid with resp_valid.
REQ-013 mem_addr  output  AW  RAM word address (read and write).
REQ-014 mem_wdata  output  32  RAM write data, byte-lane aligned.
REQ-015 mem_byteena  output  4  RAM byte enables.
REQ-016 mem_we  output  1  RAM write enable.
REQ-017 mem_rdata  input  32  RAM read data; registered, valid one cycle after mem_addr is presented.

Function
REQ-018 States: IDLE, A0, A1, CAP, RESP.
REQ-019 Request acceptance:
- Accept when req_valid and req_ready are both high.
- Latch all req_* fields at acceptance.
- Go to RESP if the memop is illegal, otherwise to A0.
REQ-020 Illegal memops:
- Loads: 011, 110, 111.
- Stores: bits [1:0] = 11.
- An illegal request issues no RAM access and returns resp_err=1.
REQ-021 Access size and split:
- Size n = 1, 2 or 4 bytes from memop[1:0]; o = addr[1:0]; W = addr[AW+1:2].
- The access is split when o+n > 4.
- Split accesses touch word W, then word W+1 modulo 2^AW (0x7FFF wraps to 0x0000).
REQ-022 Byte enables:
- Window bytes o..o+n-1 of the 8-byte span {W+1, W}.
- A0 drives lanes 0-3 of that window on word W.
- A1 drives lanes 4-7 on word W+1.
REQ-023 Write data: mem_wdata is the low half in A0 and the high half in A1 of ({32'b0, wdata} << 8*o).
REQ-024 mem_we equals the latched req_we during A0/A1; otherwise 0.
REQ-025 Outside A0/A1: mem_byteena = 0 and mem_addr holds its last value.
REQ-026 Load sequence:
- Unsplit: A0 -> CAP -> RESP.
- Split: A0 -> A1 -> CAP -> RESP.
- Word W is captured on the cycle after A0; word W+1 is captured in CAP.
REQ-027 Store sequence:
- Unsplit: A0 -> RESP.
- Split: A0 -> A1 -> RESP.
REQ-028 Load result:
- Compute ({wordW1, wordW} >> 8*o), using 0 for wordW1 when unsplit.
- Then extend: sign for 000/001, zero for 100/101, none for 010.
REQ-029 RESP behaviour:
- resp_valid=1 for exactly one cycle, then return to IDLE.
- No backpressure; resp_rdata and resp_err stay stable until the next RESP.
REQ-030 Latency from the acceptance edge to the resp_valid cycle:
- Unsplit store: 2 cycles.
- Unsplit load: 3 cycles.
- Split store: 3 cycles.
- Split load: 4 cycles.
- Error: 1 cycle.
REQ-031 req_valid seen outside IDLE is ignored (req_ready=0); there is no request queue.

Reset
REQ-032 rst_n low immediately forces:
- State IDLE.
- req_ready=1.
- resp_valid=0, resp_rdata=0, resp_err=0.
- mem_we=0, mem_byteena=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset during A1 of a split store aborts the store; word W stays written and word W+1 is not written.
REQ-034 The first request can be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-035 Store word at 0x100, data 0xDEADBEEF:
- mem_addr=0x40, byteena=1111, we=1 in A0.
- resp_valid 2 cycles after acceptance.
- A following lw at 0x100 returns 0xDEADBEEF at 3 cycles.
REQ-036 sb 0x80 to 0x103, then lb and lbu at 0x103:
- Byteena=1000, wdata=0x80000000.
- lb returns 0xFFFFFF80; lbu returns 0x00000080.
REQ-037 Split sw 0x11223344 at 0x0000_0006:
- A0: addr=1, byteena=1100, wdata=0x33440000.
- A1: addr=2, byteena=0011, wdata=0x00001122.
- lw at 0x6 returns 0x11223344 with latency 4.
REQ-038 Wrap: lh at byte address 0x1FFFF (AW=15) accesses word 0x7FFF then word 0x0000; result is {byte0 of word0, byte3 of word 0x7FFF} sign-extended.
REQ-039 Load memop 011:
- resp_err=1, resp_rdata=0, 1-cycle latency.
- mem_byteena stays 0 throughout.
REQ-040 Reset mid-operation:
- Assert rst_n=0 during A1 of the split store in REQ-037.
- All outputs go to reset values asynchronously and no resp_valid is produced.
- Word 1 lanes 2-3 hold 0x3344 and word 2 is unchanged.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: turns CPU byte/half/word accesses into one or two
// word accesses on a registered-read RAM port, with lane steering and load extension.
module lsu_ctrl #(
  parameter int unsigned AW = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_memop,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_byteena,
  output logic          mem_we,
  input  logic [31:0]   mem_rdata
);

  typedef enum logic [2:0] {S_IDLE, S_A0, S_A1, S_CAP, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [2:0]    memop_q, memop_d;
  logic [1:0]    off_q, off_d;
  logic [AW-1:0] word_q, word_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [AW-1:0] addr_q, addr_d;

  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic        split;
  logic [4:0]  shamt;
  logic [63:0] wspan;
  logic [63:0] rspan;
  logic [31:0] rshift;
  logic [31:0] rext;
  logic        req_illegal;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:AW+2];

  always_comb begin
    if (req_we) req_illegal = (req_memop[1:0] == 2'b11);
    else        req_illegal = (req_memop == 3'b011) || (req_memop == 3'b110) ||
                              (req_memop == 3'b111);
  end

  // Lane mask spans the 8-byte window {W+1, W}; any bit in the upper half means a split access.
  always_comb begin
    case (memop_q[1:0])
      2'b00:   size_mask = 4'b0001;
      2'b01:   size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
    lane_mask = {4'b0000, size_mask} << off_q;
    split     = |lane_mask[7:4];
    shamt     = {off_q, 3'b000};
    wspan     = {32'h0, wdata_q} << shamt;
  end

  // Word W arrives in lo_q (split) or directly on mem_rdata (unsplit) while in CAP.
  always_comb begin
    rspan  = split ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
    rshift = 32'(rspan >> shamt);
    case (memop_q)
      3'b000:  rext = {{24{rshift[7]}}, rshift[7:0]};
      3'b001:  rext = {{16{rshift[15]}}, rshift[15:0]};
      3'b100:  rext = {24'h0, rshift[7:0]};
      3'b101:  rext = {16'h0, rshift[15:0]};
      default: rext = rshift;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    memop_d     = memop_q;
    off_d       = off_q;
    word_d      = word_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    addr_d      = addr_q;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    mem_we      = 1'b0;
    mem_byteena = '0;
    mem_wdata   = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          memop_d = req_memop;
          off_d   = req_addr[1:0];
          word_d  = req_addr[AW+1:2];
          wdata_d = req_wdata;
          if (req_illegal) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_RESP;
          end else begin
            addr_d  = req_addr[AW+1:2];
            state_d = S_A0;
          end
        end
      end
      S_A0: begin
        mem_we      = we_q;
        mem_byteena = lane_mask[3:0];
        mem_wdata   = wspan[31:0];
        if (split) begin
          addr_d  = word_q + AW'(1);
          state_d = S_A1;
        end else if (we_q) begin
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          state_d = S_CAP;
        end
      end
      S_A1: begin
        mem_we      = we_q;
        mem_byteena = lane_mask[7:4];
        mem_wdata   = wspan[63:32];
        if (we_q) begin
          err_d   = 1'b0;
          rdata_d = '0;
          state_d = S_RESP;
        end else begin
          lo_d    = mem_rdata;
          state_d = S_CAP;
        end
      end
      S_CAP: begin
        err_d   = 1'b0;
        rdata_d = rext;
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      memop_q <= '0;
      off_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      memop_q <= memop_d;
      off_q   <= off_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      lo_q    <= lo_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
    end
  end

  assign mem_addr   = addr_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed scenarios plus random traffic checked against a
// byte-addressed reference memory.
module tb_lsu_ctrl;
  localparam int unsigned AW     = 15;
  localparam int unsigned NWORDS = 1 << AW;
  localparam int unsigned NBYTES = 1 << (AW + 2);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_memop;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byteena;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteena(mem_byteena),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // RAM attached to the DUT: byte-enabled write, registered read.
  logic [31:0] ram [0:NWORDS-1] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we)
      for (int j = 0; j < 4; j++)
        if (mem_byteena[j]) ram[mem_addr][8*j +: 8] <= mem_wdata[8*j +: 8];
    mem_rdata <= ram[mem_addr];
  end

  // Reference: flat byte memory, little-endian, addresses wrap at NBYTES.
  logic [7:0] gmem [0:NBYTES-1] = '{default: 8'h0};

  logic [3:0]    tr_be [0:31];
  logic [AW-1:0] tr_ad [0:31];
  logic          tr_we [0:31];
  logic [31:0]   tr_wd [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [2:0] op);
    case (op[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_err(input logic we, input logic [2:0] op);
    if (we) return op[1:0] == 2'b11;
    return (op == 3'd3) || (op == 3'd6) || (op == 3'd7);
  endfunction

  function automatic int exp_lat(input logic we, input logic [2:0] op, input logic [31:0] addr);
    bit sp;
    if (is_err(we, op)) return 1;
    sp = (int'(addr % 4) + int'(nbytes(op))) > 4;
    if (we) return sp ? 3 : 2;
    return sp ? 4 : 3;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] v = 32'h0;
    int unsigned n = nbytes(op);
    for (int unsigned i = 0; i < n; i++)
      v = v | ({24'h0, gmem[(addr + i) % NBYTES]} << (8 * i));
    if (op == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (op == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
    for (int unsigned i = 0; i < nbytes(op); i++)
      gmem[(addr + i) % NBYTES] = wd[8*i +: 8];
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"}, req_ready, 1);
    chk({tag, ".rvalid"}, resp_valid, 0);
    chk({tag, ".rdata"}, resp_rdata, 0);
    chk({tag, ".rerr"}, resp_err, 0);
    chk({tag, ".mwe"}, mem_we, 0);
    chk({tag, ".mbe"}, mem_byteena, 0);
    chk({tag, ".maddr"}, mem_addr, 0);
    chk({tag, ".mwdata"}, mem_wdata, 0);
  endtask

  task automatic run_req(input logic we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd,
                         output logic er);
    @(negedge clk);
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_memop = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = $urandom; req_memop = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      tr_be[k] = mem_byteena; tr_ad[k] = mem_addr; tr_we[k] = mem_we; tr_wd[k] = mem_wdata;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      chk("resp_pulse", resp_valid, 0);
      chk("resp_hold", resp_rdata, rd);
    end
  endtask

  task automatic do_check(input string tag, input logic we, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd);
    int lat;
    logic er;
    bit eer = is_err(we, op);
    int elat = exp_lat(we, op, addr);
    logic [31:0] erd = (eer || we) ? 32'h0 : exp_load(op, addr);
    run_req(we, op, addr, wd, lat, rd, er);
    chk({tag, ".lat"}, lat, elat);
    chk({tag, ".err"}, er, eer);
    chk({tag, ".rdata"}, rd, erd);
    if (we && !eer) model_store(op, addr, wd);
  endtask

  initial begin
    logic [31:0] rd;
    logic        seen_resp;
    logic [31:0] a, w;
    logic        rwe;
    logic [2:0]  rop;

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_memop = '0;
    req_addr = '0; req_wdata = '0;
    #1;
    chk_reset_outputs("por");
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;

    // Aligned word store then load.
    do_check("sw100", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, rd);
    chk("sw100.a0_addr", tr_ad[1], 15'h40);
    chk("sw100.a0_be", tr_be[1], 4'b1111);
    chk("sw100.a0_we", tr_we[1], 1);
    chk("sw100.a0_wd", tr_wd[1], 32'hDEAD_BEEF);
    do_check("lw100", 1'b0, 3'b010, 32'h0000_0100, 32'h0, rd);
    chk("lw100.const", rd, 32'hDEAD_BEEF);

    // Byte store into top lane, signed and unsigned reload.
    do_check("sb103", 1'b1, 3'b000, 32'h0000_0103, 32'h0000_0080, rd);
    chk("sb103.be", tr_be[1], 4'b1000);
    chk("sb103.wd", tr_wd[1], 32'h8000_0000);
    do_check("lb103", 1'b0, 3'b000, 32'h0000_0103, 32'h0, rd);
    chk("lb103.const", rd, 32'hFFFF_FF80);
    do_check("lbu103", 1'b0, 3'b100, 32'h0000_0103, 32'h0, rd);
    chk("lbu103.const", rd, 32'h0000_0080);

    // Split word store across words 1 and 2.
    do_check("sw6", 1'b1, 3'b010, 32'h0000_0006, 32'h1122_3344, rd);
    chk("sw6.a0_addr", tr_ad[1], 1);
    chk("sw6.a0_be", tr_be[1], 4'b1100);
    chk("sw6.a0_wd", tr_wd[1], 32'h3344_0000);
    chk("sw6.a1_addr", tr_ad[2], 2);
    chk("sw6.a1_be", tr_be[2], 4'b0011);
    chk("sw6.a1_wd", tr_wd[2], 32'h0000_1122);
    do_check("lw6", 1'b0, 3'b010, 32'h0000_0006, 32'h0, rd);
    chk("lw6.const", rd, 32'h1122_3344);

    // Halfword load wrapping from the last word to word 0.
    do_check("sb1ffff", 1'b1, 3'b000, 32'h0001_FFFF, 32'h0000_005A, rd);
    do_check("sb0", 1'b1, 3'b000, 32'h0000_0000, 32'h0000_00C3, rd);
    do_check("lhwrap", 1'b0, 3'b001, 32'h0001_FFFF, 32'h0, rd);
    chk("lhwrap.const", rd, 32'hFFFF_C35A);
    chk("lhwrap.a0_addr", tr_ad[1], 15'h7FFF);
    chk("lhwrap.a1_addr", tr_ad[2], 0);
    chk("lhwrap.a0_be", tr_be[1], 4'b1000);
    chk("lhwrap.a1_be", tr_be[2], 4'b0001);

    // Illegal memops.
    do_check("ld011", 1'b0, 3'b011, 32'h0000_0100, 32'h0, rd);
    chk("ld011.be", tr_be[1], 0);
    do_check("st11", 1'b1, 3'b111, 32'h0000_0100, 32'hFFFF_FFFF, rd);
    chk("st11.we", tr_we[1], 0);
    do_check("lw100b", 1'b0, 3'b010, 32'h0000_0100, 32'h0, rd);

    // Reset during A1 of a split store.
    do_check("clr4", 1'b1, 3'b010, 32'h0000_0004, 32'h0, rd);
    do_check("clr8", 1'b1, 3'b010, 32'h0000_0008, 32'h0, rd);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_memop = 3'b010;
    req_addr = 32'h0000_0006; req_wdata = 32'h1122_3344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort.a1_addr", mem_addr, 2);
    chk("abort.a1_be", mem_byteena, 4'b0011);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    seen_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen_resp = seen_resp | resp_valid;
    end
    chk("abort.no_resp", seen_resp, 0);
    gmem[6] = 8'h44;
    gmem[7] = 8'h33;
    @(posedge clk);
    #1 rst_n = 1'b1;
    do_check("abort.lw4", 1'b0, 3'b010, 32'h0000_0004, 32'h0, rd);
    chk("abort.w1", rd, 32'h3344_0000);
    do_check("abort.lw8", 1'b0, 3'b010, 32'h0000_0008, 32'h0, rd);

    // Random traffic confined to the two ends of the address space.
    for (int t = 0; t < 300; t++) begin
      w = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) w = w + (NBYTES - 64);
      a = {15'($urandom), w[16:0]};
      rwe = 1'($urandom);
      rop = 3'($urandom);
      do_check("rnd", rwe, rop, a, $urandom, rd);
    end

    for (int unsigned wi = 0; wi < 32; wi++) begin
      int unsigned wa = (wi < 16) ? wi : (NWORDS - 32 + wi);
      chk("ramword", ram[wa], {gmem[4*wa+3], gmem[4*wa+2], gmem[4*wa+1], gmem[4*wa]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
